// File: rtl/uart_cmd_engine.sv
// rtl/uart_cmd_engine.sv - byte command parser and memory access engine between UART rx and tx
module uart_cmd_engine #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int MEM_DEPTH   = 128,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [7:0]        ovr_cnt
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [DATA_W-1:0] CMD_WR = DATA_W'(8'h57);
  localparam logic [DATA_W-1:0] CMD_RD = DATA_W'(8'h52);
  localparam logic [DATA_W-1:0] RSP_ACK = DATA_W'(8'h06);
  localparam logic [DATA_W-1:0] RSP_NAK = DATA_W'(8'h15);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, RD_WAIT, SEND
  } state_t;

  state_t            state, state_n;
  logic              wr_q, wr_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] txd_q, txd_n;
  logic [TW-1:0]     tmo_q, tmo_n;
  logic [7:0]        ovr_q, ovr_n;
  logic              drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      tmo_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state   <= state_n;
      wr_q    <= wr_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      txd_q   <= txd_n;
      tmo_q   <= tmo_n;
      ovr_q   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    wr_n    = wr_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    txd_n   = txd_q;
    tmo_n   = tmo_q;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        tmo_n = '0;
        if (rx_valid) begin
          if (rx_err || (rx_data != CMD_WR && rx_data != CMD_RD)) begin
            txd_n   = RSP_NAK;
            state_n = SEND;
          end else begin
            wr_n    = (rx_data == CMD_WR);
            state_n = GET_ADDR;
          end
        end
      end
      GET_ADDR: begin
        if (rx_valid) begin
          tmo_n = '0;
          if (rx_err) begin
            txd_n   = RSP_NAK;
            state_n = SEND;
          end else begin
            addr_n = ADDR_W'(rx_data);
            if (int'(rx_data) >= MEM_DEPTH) begin
              txd_n   = RSP_NAK;
              state_n = SEND;
            end else begin
              state_n = wr_q ? GET_DATA : MEM_RD;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abandoned command: back to IDLE without any response
          tmo_n   = '0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo_q + 1'b1;
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          tmo_n = '0;
          if (rx_err) begin
            txd_n   = RSP_NAK;
            state_n = SEND;
          end else begin
            wdata_n = rx_data;
            state_n = MEM_WR;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_n   = '0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo_q + 1'b1;
        end
      end
      MEM_WR: begin
        drop    = rx_valid;
        txd_n   = RSP_ACK;
        state_n = SEND;
      end
      MEM_RD: begin
        drop    = rx_valid;
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        drop    = rx_valid;
        txd_n   = mem_rdata;
        state_n = SEND;
      end
      SEND: begin
        // A byte arriving on the handshake cycle is still dropped
        drop = rx_valid;
        if (tx_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    ovr_n = (drop && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
  end

  assign tx_data   = txd_q;
  assign tx_valid  = (state == SEND);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state == MEM_WR);
  assign mem_re    = (state == MEM_RD);
  assign busy      = (state != IDLE);
  assign ovr_cnt   = ovr_q;

endmodule

// File: tb/tb_uart_cmd_engine.sv
// tb/tb_uart_cmd_engine.sv - directed self-checking bench for uart_cmd_engine
module tb_uart_cmd_engine;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, mem_re, busy;
  logic [7:0] ovr_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_tx = 0;
  int n_we = 0;
  int n_re = 0;
  int snap_tx, snap_we, snap_re;
  logic stable;
  logic [7:0] mem [0:127];

  always #5 clk = ~clk;

  uart_cmd_engine #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(128), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .ovr_cnt(ovr_cnt)
  );

  // Memory model with one-cycle read latency, plus handshake counters
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[6:0]];
    if (rst_n && tx_valid && tx_ready) n_tx <= n_tx + 1;
    if (rst_n && mem_we) n_we <= n_we + 1;
    if (rst_n && mem_re) n_re <= n_re + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = err;
    step();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem_rdata = 8'h00;
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0; tx_ready = 1'b1;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_mem_strobes", 32'({mem_we, mem_re}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_ovr", 32'(ovr_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Write 0xA5 to 0x10
    send_byte(8'h57, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'hA5, 1'b0);
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_addr", 32'(mem_addr), 32'h10);
    chk("wr_data", 32'(mem_wdata), 32'hA5);
    chk("wr_txv_early", 32'(tx_valid), 32'd0);
    step();
    chk("wr_txv", 32'(tx_valid), 32'd1);
    chk("wr_ack", 32'(tx_data), 32'h06);
    chk("wr_we_single", 32'(mem_we), 32'd0);
    step();
    chk("wr_idle", 32'({busy, tx_valid}), 32'd0);

    // Read back 0x10: strobe at t+1, response at t+3
    send_byte(8'h52, 1'b0); send_byte(8'h10, 1'b0);
    chk("rd_re", 32'(mem_re), 32'd1);
    step();
    chk("rd_wait", 32'({mem_re, tx_valid}), 32'd0);
    step();
    chk("rd_txv", 32'(tx_valid), 32'd1);
    chk("rd_data", 32'(tx_data), 32'hA5);
    step();

    // Out-of-range address, then 0x33 parsed as a fresh bad opcode
    snap_we = n_we;
    send_byte(8'h57, 1'b0); send_byte(8'h80, 1'b0);
    chk("oor_txv", 32'(tx_valid), 32'd1);
    chk("oor_nak", 32'(tx_data), 32'h15);
    step();
    send_byte(8'h33, 1'b0);
    chk("oor_second_nak", 32'({tx_valid, tx_data}), 32'h115);
    step();
    chk("oor_no_we", 32'(n_we), 32'(snap_we));
    chk("oor_no_drop", 32'(ovr_cnt), 32'd0);

    // Bad opcode, then rx_err on the address byte
    send_byte(8'h41, 1'b0);
    chk("badop_nak", 32'({tx_valid, tx_data}), 32'h115);
    step();
    snap_re = n_re;
    send_byte(8'h52, 1'b0); send_byte(8'h05, 1'b1);
    chk("rxerr_nak", 32'({tx_valid, tx_data}), 32'h115);
    step();
    chk("rxerr_no_re", 32'(n_re), 32'(snap_re));

    // Timeout: busy holds for TMO-1 idle edges, drops on the next one
    snap_tx = n_tx; snap_we = n_we;
    send_byte(8'h57, 1'b0);
    repeat (TMO - 1) step();
    chk("tmo_busy_before", 32'(busy), 32'd1);
    step();
    chk("tmo_busy_after", 32'(busy), 32'd0);
    chk("tmo_no_tx", 32'(n_tx), 32'(snap_tx));
    chk("tmo_no_we", 32'(n_we), 32'(snap_we));
    send_byte(8'h52, 1'b0); send_byte(8'h00, 1'b0);
    step(); step();
    chk("tmo_rd_data", 32'({tx_valid, tx_data}), 32'h15A);
    step();

    // Backpressure with three dropped bytes during SEND
    tx_ready = 1'b0;
    send_byte(8'h57, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'hC3, 1'b0);
    step();
    snap_tx = n_tx;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rx_data  = 8'h52;
      rx_valid = (i == 5 || i == 20 || i == 40);
      step();
      rx_valid = 1'b0;
      if (!(tx_valid === 1'b1 && tx_data === 8'h06)) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_ovr", 32'(ovr_cnt), 32'd3);
    chk("bp_no_tx_yet", 32'(n_tx), 32'(snap_tx));
    // Byte arriving with the handshake is dropped and does not start a command
    tx_ready = 1'b1; rx_data = 8'h41; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    chk("bp_single_tx", 32'(n_tx), 32'(snap_tx + 1));
    chk("bp_idle", 32'({busy, tx_valid}), 32'd0);
    chk("bp_ovr_edge", 32'(ovr_cnt), 32'd4);

    // Reset during GET_DATA
    snap_we = n_we;
    send_byte(8'h57, 1'b0); send_byte(8'h30, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_outs", 32'({tx_valid, mem_we, mem_re, tx_data, mem_addr, mem_wdata, ovr_cnt}), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    send_byte(8'h52, 1'b0); send_byte(8'h10, 1'b0);
    step(); step();
    chk("mrst_rd_data", 32'({tx_valid, tx_data}), 32'h1A5);
    step();
    chk("mrst_no_we", 32'(n_we), 32'(snap_we));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
